// File: rtl/cd_dma_pkg.sv
// Shared types and constants for the CD DMA engine.
// Fill mode is compiled in only when CD_DMA_FILL_EN is defined.
package cd_dma_pkg;

  localparam int unsigned AddrW = 23;

  typedef enum logic [2:0] {
    StIdle,
    StBusReq,
    StRead,
    StWrite,
    StRelease
  } dma_state_e;

endpackage

// File: rtl/cd_dma_access.sv
// Single-access MEM_REQ/MEM_ACK handshake. Drops MEM_REQ on acknowledge, which
// always leaves at least one idle cycle before the next access is issued.
module cd_dma_access
  import cd_dma_pkg::*;
(
  input  logic             clk_i,
  input  logic             nRESET,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [15:0]      wdata_i,
  output logic             done_o,
  output logic [15:0]      rdata_o,
  output logic             MEM_REQ,
  output logic             MEM_WE,
  output logic [AddrW-1:0] MEM_ADDR,
  output logic [15:0]      MEM_WDATA,
  input  logic [15:0]      MEM_RDATA,
  input  logic             MEM_ACK
);

  logic             mem_req_q;
  logic             mem_we_q;
  logic [AddrW-1:0] mem_addr_q;
  logic [15:0]      mem_wdata_q;
  logic [15:0]      rdata_q;

  always_ff @(negedge clk_i or negedge nRESET) begin
    if (!nRESET) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else if (mem_req_q) begin
      if (MEM_ACK) begin
        mem_req_q <= 1'b0;
        if (!mem_we_q) rdata_q <= MEM_RDATA;
      end
    end else if (req_i) begin
      mem_req_q  <= 1'b1;
      mem_we_q   <= we_i;
      mem_addr_q <= addr_i;
      if (we_i) mem_wdata_q <= wdata_i;
    end
  end

  assign done_o    = mem_req_q & MEM_ACK;
  assign rdata_o   = rdata_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;

endmodule

// File: rtl/cd_dma_ctrl.sv
// CD DMA engine: bus arbitration plus word copy (or fill, with CD_DMA_FILL_EN)
// between 23-bit word addresses. State advances on the falling clock edge.
module cd_dma_ctrl
  import cd_dma_pkg::*;
(
  input  logic             CLK_68KCLK,
  input  logic             nRESET,
  input  logic             DMA_START,
  input  logic             DMA_STOP,
  input  logic             DMA_FILL,
  input  logic [AddrW-1:0] DMA_SOURCE,
  input  logic [AddrW-1:0] DMA_DEST,
  input  logic [15:0]      DMA_VALUE,
  input  logic [15:0]      DMA_COUNT,
  output logic             nBR,
  input  logic             nBG,
  output logic             nBGACK,
  output logic             MEM_REQ,
  output logic             MEM_WE,
  output logic [AddrW-1:0] MEM_ADDR,
  output logic [15:0]      MEM_WDATA,
  input  logic [15:0]      MEM_RDATA,
  input  logic             MEM_ACK,
  output logic             BUSY,
  output logic             DONE_IRQ
);

  dma_state_e       state_q, state_d;
  logic [AddrW-1:0] src_q, src_d, dst_q, dst_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             zdone_q, zdone_d;
  logic             fill_mode;
  logic [15:0]      fill_word;

  logic             acc_req, acc_we, acc_done;
  logic [AddrW-1:0] acc_addr;
  logic [15:0]      acc_wdata, acc_rdata;

`ifdef CD_DMA_FILL_EN
  logic        fill_q, fill_d;
  logic [15:0] val_q, val_d;

  always_ff @(negedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET) begin
      fill_q <= 1'b0;
      val_q  <= '0;
    end else begin
      fill_q <= fill_d;
      val_q  <= val_d;
    end
  end

  always_comb begin
    fill_d = fill_q;
    val_d  = val_q;
    if (state_q == StIdle && !DMA_STOP && DMA_START && DMA_COUNT != '0) begin
      fill_d = DMA_FILL;
      val_d  = DMA_VALUE;
    end
  end

  assign fill_mode = fill_q;
  assign fill_word = val_q;
`else
  logic unused_fill;
  assign unused_fill = ^{DMA_FILL, DMA_VALUE};
  assign fill_mode   = 1'b0;
  assign fill_word   = '0;
`endif

  always_ff @(negedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      zdone_q <= zdone_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    zdone_d   = 1'b0;
    acc_req   = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = src_q;
    acc_wdata = acc_rdata;
    unique case (state_q)
      StIdle: begin
        // Stop wins over a simultaneous start.
        if (!DMA_STOP && DMA_START) begin
          if (DMA_COUNT != '0) begin
            src_d   = DMA_SOURCE;
            dst_d   = DMA_DEST;
            cnt_d   = DMA_COUNT;
            state_d = StBusReq;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      StBusReq: begin
        if (DMA_STOP)  state_d = StIdle;
        else if (!nBG) state_d = fill_mode ? StWrite : StRead;
      end
      StRead: begin
        acc_req = 1'b1;
        if (acc_done) state_d = StWrite;
      end
      StWrite: begin
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = dst_q;
        acc_wdata = fill_mode ? fill_word : acc_rdata;
        if (acc_done) begin
          dst_d = dst_q + 1'b1;
          if (!fill_mode) src_d = src_q + 1'b1;
          cnt_d = cnt_q - 16'd1;
          // Abort is only honoured here, once the write handshake has finished.
          if (cnt_q == 16'd1 || DMA_STOP) state_d = StRelease;
          else                            state_d = fill_mode ? StWrite : StRead;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  cd_dma_access u_access (
    .clk_i     (CLK_68KCLK),
    .nRESET    (nRESET),
    .req_i     (acc_req),
    .we_i      (acc_we),
    .addr_i    (acc_addr),
    .wdata_i   (acc_wdata),
    .done_o    (acc_done),
    .rdata_o   (acc_rdata),
    .MEM_REQ   (MEM_REQ),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA),
    .MEM_ACK   (MEM_ACK)
  );

  assign nBR      = (state_q != StBusReq);
  assign nBGACK   = !(state_q == StRead || state_q == StWrite);
  assign BUSY     = (state_q == StBusReq || state_q == StRead || state_q == StWrite);
  assign DONE_IRQ = (state_q == StRelease) || zdone_q;

endmodule

// File: tb/tb_cd_dma_ctrl.sv
// Directed bench for cd_dma_ctrl with a one-wait-state memory responder.
module tb_cd_dma_ctrl;

  logic        CLK_68KCLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        DMA_START = 1'b0, DMA_STOP = 1'b0, DMA_FILL = 1'b0;
  logic [22:0] DMA_SOURCE = '0, DMA_DEST = '0;
  logic [15:0] DMA_VALUE = '0, DMA_COUNT = '0;
  logic        nBR, nBGACK, MEM_REQ, MEM_WE, BUSY, DONE_IRQ;
  logic        nBG = 1'b1;
  logic [22:0] MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic [15:0] MEM_RDATA = '0;
  logic        MEM_ACK = 1'b0;

  int n_checks = 0, n_pass = 0;
  int irq_cnt = 0, nbr_low_cnt = 0, gap_viol = 0;
  logic [22:0] rd_addr_q[$], wr_addr_q[$];
  logic [15:0] wr_data_q[$];

  cd_dma_ctrl dut (
    .CLK_68KCLK (CLK_68KCLK), .nRESET (nRESET),
    .DMA_START  (DMA_START),  .DMA_STOP (DMA_STOP), .DMA_FILL (DMA_FILL),
    .DMA_SOURCE (DMA_SOURCE), .DMA_DEST (DMA_DEST),
    .DMA_VALUE  (DMA_VALUE),  .DMA_COUNT (DMA_COUNT),
    .nBR (nBR), .nBG (nBG), .nBGACK (nBGACK),
    .MEM_REQ (MEM_REQ), .MEM_WE (MEM_WE), .MEM_ADDR (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA), .MEM_RDATA (MEM_RDATA), .MEM_ACK (MEM_ACK),
    .BUSY (BUSY), .DONE_IRQ (DONE_IRQ)
  );

  always #5 CLK_68KCLK = ~CLK_68KCLK;

  // Memory returns addr[15:0] ^ 16'h5A5A; ACK one cycle after REQ is seen.
  always @(posedge CLK_68KCLK) begin
    if (DONE_IRQ) irq_cnt++;
    if (!nBR) nbr_low_cnt++;
    if (MEM_REQ && MEM_ACK) gap_viol++;
    if (MEM_REQ && !MEM_ACK) begin
      MEM_ACK = 1'b1;
      if (MEM_WE) begin
        wr_addr_q.push_back(MEM_ADDR);
        wr_data_q.push_back(MEM_WDATA);
      end else begin
        rd_addr_q.push_back(MEM_ADDR);
        MEM_RDATA = MEM_ADDR[15:0] ^ 16'h5A5A;
      end
    end else begin
      MEM_ACK = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK_68KCLK);
    #1;
  endtask

  task automatic start_xfer(input logic [22:0] src, input logic [22:0] dst,
                            input logic [15:0] cnt, input logic fill, input logic [15:0] val);
    DMA_SOURCE = src; DMA_DEST = dst; DMA_COUNT = cnt; DMA_FILL = fill; DMA_VALUE = val;
    DMA_START = 1'b1;
    tick();
    DMA_START = 1'b0;
  endtask

  task automatic wait_irq(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (DONE_IRQ) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    tick();
    n_checks++; if (nBR !== 1'b1) $display("FAIL rst_nbr: got %b want 1", nBR); else n_pass++;
    n_checks++; if (nBGACK !== 1'b1) $display("FAIL rst_nbgack: got %b want 1", nBGACK); else n_pass++;
    n_checks++; if (MEM_REQ !== 1'b0) $display("FAIL rst_req: got %b want 0", MEM_REQ); else n_pass++;
    n_checks++; if (MEM_ADDR !== 23'h0) $display("FAIL rst_addr: got %h want 0", MEM_ADDR); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL rst_busy: got %b want 0", BUSY); else n_pass++;
    n_checks++; if (DONE_IRQ !== 1'b0) $display("FAIL rst_irq: got %b want 0", DONE_IRQ); else n_pass++;
    nRESET = 1'b1;
    tick();
  endtask

  task automatic test_copy();
    int rb = rd_addr_q.size(), wb = wr_addr_q.size(), i0 = irq_cnt;
    bit seen;
    start_xfer(23'h100000, 23'h200000, 16'd3, 1'b0, 16'h0);
    n_checks++; if (nBR !== 1'b0) $display("FAIL copy_nbr_req: got %b want 0", nBR); else n_pass++;
    n_checks++; if (BUSY !== 1'b1) $display("FAIL copy_busy: got %b want 1", BUSY); else n_pass++;
    tick(); tick();
    nBG = 1'b0;
    wait_irq(seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL copy_irq_timeout: got %b want 1", seen); else n_pass++;
    tick(); tick();
    nBG = 1'b1;
    n_checks++; if (rd_addr_q.size() - rb !== 3) $display("FAIL copy_nrd: got %0d want 3", rd_addr_q.size() - rb); else n_pass++;
    n_checks++; if (wr_addr_q.size() - wb !== 3) $display("FAIL copy_nwr: got %0d want 3", wr_addr_q.size() - wb); else n_pass++;
    if (rd_addr_q.size() >= rb + 3 && wr_addr_q.size() >= wb + 3) begin
      n_checks++; if (rd_addr_q[rb] !== 23'h100000) $display("FAIL copy_rd0: got %h want 100000", rd_addr_q[rb]); else n_pass++;
      n_checks++; if (rd_addr_q[rb+2] !== 23'h100002) $display("FAIL copy_rd2: got %h want 100002", rd_addr_q[rb+2]); else n_pass++;
      n_checks++; if (wr_addr_q[wb] !== 23'h200000) $display("FAIL copy_wr0: got %h want 200000", wr_addr_q[wb]); else n_pass++;
      n_checks++; if (wr_addr_q[wb+2] !== 23'h200002) $display("FAIL copy_wr2: got %h want 200002", wr_addr_q[wb+2]); else n_pass++;
      n_checks++; if (wr_data_q[wb] !== 16'h5A5A) $display("FAIL copy_wd0: got %h want 5a5a", wr_data_q[wb]); else n_pass++;
      n_checks++; if (wr_data_q[wb+1] !== 16'h5A5B) $display("FAIL copy_wd1: got %h want 5a5b", wr_data_q[wb+1]); else n_pass++;
      n_checks++; if (wr_data_q[wb+2] !== 16'h5A58) $display("FAIL copy_wd2: got %h want 5a58", wr_data_q[wb+2]); else n_pass++;
    end
    n_checks++; if (irq_cnt - i0 !== 1) $display("FAIL copy_nirq: got %0d want 1", irq_cnt - i0); else n_pass++;
    n_checks++; if (nBGACK !== 1'b1) $display("FAIL copy_nbgack: got %b want 1", nBGACK); else n_pass++;
    n_checks++; if (gap_viol !== 0) $display("FAIL copy_req_gap: got %0d want 0", gap_viol); else n_pass++;
  endtask

  task automatic test_zero_count();
    int nb = nbr_low_cnt;
    start_xfer(23'h000010, 23'h000020, 16'd0, 1'b0, 16'h0);
    n_checks++; if (DONE_IRQ !== 1'b1) $display("FAIL zero_irq: got %b want 1", DONE_IRQ); else n_pass++;
    tick();
    n_checks++; if (DONE_IRQ !== 1'b0) $display("FAIL zero_irq_pulse: got %b want 0", DONE_IRQ); else n_pass++;
    tick();
    n_checks++; if (nbr_low_cnt - nb !== 0) $display("FAIL zero_nbr: got %0d want 0", nbr_low_cnt - nb); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL zero_busy: got %b want 0", BUSY); else n_pass++;
  endtask

  task automatic test_stop_in_read();
    int rb = rd_addr_q.size(), wb = wr_addr_q.size(), i0 = irq_cnt;
    bit seen;
    start_xfer(23'h000010, 23'h000400, 16'd5, 1'b0, 16'h0);
    nBG = 1'b0;
    for (int i = 0; i < 100 && rd_addr_q.size() - rb < 2; i++) tick();
    n_checks++; if (rd_addr_q.size() - rb !== 2) $display("FAIL stop_rd2_timeout: got %0d want 2", rd_addr_q.size() - rb); else n_pass++;
    DMA_STOP = 1'b1;
    wait_irq(seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL stop_irq_timeout: got %b want 1", seen); else n_pass++;
    tick(); tick();
    DMA_STOP = 1'b0; nBG = 1'b1;
    n_checks++; if (wr_addr_q.size() - wb !== 2) $display("FAIL stop_nwr: got %0d want 2", wr_addr_q.size() - wb); else n_pass++;
    if (wr_data_q.size() >= wb + 2) begin
      n_checks++; if (wr_data_q[wb+1] !== 16'h5A4B) $display("FAIL stop_wd1: got %h want 5a4b", wr_data_q[wb+1]); else n_pass++;
    end
    n_checks++; if (irq_cnt - i0 !== 1) $display("FAIL stop_nirq: got %0d want 1", irq_cnt - i0); else n_pass++;
    n_checks++; if (nBGACK !== 1'b1) $display("FAIL stop_nbgack: got %b want 1", nBGACK); else n_pass++;
  endtask

  task automatic test_stop_busreq();
    int i0 = irq_cnt;
    start_xfer(23'h000100, 23'h000200, 16'd4, 1'b0, 16'h0);
    n_checks++; if (nBR !== 1'b0) $display("FAIL breq_nbr_low: got %b want 0", nBR); else n_pass++;
    DMA_STOP = 1'b1;
    tick();
    n_checks++; if (nBR !== 1'b1) $display("FAIL breq_abort_nbr: got %b want 1", nBR); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL breq_abort_busy: got %b want 0", BUSY); else n_pass++;
    start_xfer(23'h000100, 23'h000200, 16'd4, 1'b0, 16'h0);
    tick();
    n_checks++; if (nBR !== 1'b1) $display("FAIL stop_start_nbr: got %b want 1", nBR); else n_pass++;
    DMA_STOP = 1'b0;
    tick();
    n_checks++; if (irq_cnt - i0 !== 0) $display("FAIL breq_nirq: got %0d want 0", irq_cnt - i0); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int rb = rd_addr_q.size(), wb = wr_addr_q.size();
    bit seen;
    start_xfer(23'h300000, 23'h310000, 16'd2, 1'b0, 16'h0);
    tick();
    start_xfer(23'h000100, 23'h000200, 16'd7, 1'b0, 16'h0);
    nBG = 1'b0;
    wait_irq(seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL busy_irq_timeout: got %b want 1", seen); else n_pass++;
    tick();
    nBG = 1'b1;
    n_checks++; if (wr_addr_q.size() - wb !== 2) $display("FAIL busy_nwr: got %0d want 2", wr_addr_q.size() - wb); else n_pass++;
    if (rd_addr_q.size() >= rb + 1 && wr_addr_q.size() >= wb + 2) begin
      n_checks++; if (rd_addr_q[rb] !== 23'h300000) $display("FAIL busy_rd0: got %h want 300000", rd_addr_q[rb]); else n_pass++;
      n_checks++; if (wr_addr_q[wb+1] !== 23'h310001) $display("FAIL busy_wr1: got %h want 310001", wr_addr_q[wb+1]); else n_pass++;
    end
  endtask

`ifdef CD_DMA_FILL_EN
  task automatic test_fill();
    int rb = rd_addr_q.size(), wb = wr_addr_q.size();
    bit seen;
    logic [22:0] exp_a [4];
    exp_a[0] = 23'h7FFFFE; exp_a[1] = 23'h7FFFFF; exp_a[2] = 23'h000000; exp_a[3] = 23'h000001;
    start_xfer(23'h000000, 23'h7FFFFE, 16'd4, 1'b1, 16'hA5A5);
    nBG = 1'b0;
    wait_irq(seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL fill_irq_timeout: got %b want 1", seen); else n_pass++;
    tick();
    nBG = 1'b1;
    n_checks++; if (rd_addr_q.size() - rb !== 0) $display("FAIL fill_nrd: got %0d want 0", rd_addr_q.size() - rb); else n_pass++;
    n_checks++; if (wr_addr_q.size() - wb !== 4) $display("FAIL fill_nwr: got %0d want 4", wr_addr_q.size() - wb); else n_pass++;
    if (wr_addr_q.size() >= wb + 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (wr_addr_q[wb+i] !== exp_a[i]) $display("FAIL fill_wa%0d: got %h want %h", i, wr_addr_q[wb+i], exp_a[i]); else n_pass++;
        n_checks++; if (wr_data_q[wb+i] !== 16'hA5A5) $display("FAIL fill_wd%0d: got %h want a5a5", i, wr_data_q[wb+i]); else n_pass++;
      end
    end
  endtask
`else
  // Fill request is ignored; also exercises pointer wrap at the top of memory.
  task automatic test_fill();
    int rb = rd_addr_q.size(), wb = wr_addr_q.size();
    bit seen;
    start_xfer(23'h7FFFFF, 23'h7FFFFF, 16'd2, 1'b1, 16'h1234);
    nBG = 1'b0;
    wait_irq(seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL nofill_irq_timeout: got %b want 1", seen); else n_pass++;
    tick();
    nBG = 1'b1;
    n_checks++; if (rd_addr_q.size() - rb !== 2) $display("FAIL nofill_nrd: got %0d want 2", rd_addr_q.size() - rb); else n_pass++;
    if (rd_addr_q.size() >= rb + 2 && wr_addr_q.size() >= wb + 2) begin
      n_checks++; if (rd_addr_q[rb+1] !== 23'h000000) $display("FAIL nofill_rd_wrap: got %h want 000000", rd_addr_q[rb+1]); else n_pass++;
      n_checks++; if (wr_addr_q[wb+1] !== 23'h000000) $display("FAIL nofill_wr_wrap: got %h want 000000", wr_addr_q[wb+1]); else n_pass++;
      n_checks++; if (wr_data_q[wb] !== 16'hA5A5) $display("FAIL nofill_wd0: got %h want a5a5", wr_data_q[wb]); else n_pass++;
      n_checks++; if (wr_data_q[wb+1] !== 16'h5A5A) $display("FAIL nofill_wd1: got %h want 5a5a", wr_data_q[wb+1]); else n_pass++;
    end
  endtask
`endif

  task automatic test_reset_mid_write();
    int wb = wr_addr_q.size(), i0 = irq_cnt;
    start_xfer(23'h050000, 23'h060000, 16'd8, 1'b0, 16'h0);
    nBG = 1'b0;
    for (int i = 0; i < 100 && wr_addr_q.size() == wb; i++) tick();
    n_checks++; if (MEM_WE !== 1'b1) $display("FAIL rmid_in_write: got %b want 1", MEM_WE); else n_pass++;
    nRESET = 1'b0;
    #1;
    n_checks++; if (nBGACK !== 1'b1) $display("FAIL rmid_nbgack: got %b want 1", nBGACK); else n_pass++;
    n_checks++; if (MEM_REQ !== 1'b0) $display("FAIL rmid_req: got %b want 0", MEM_REQ); else n_pass++;
    n_checks++; if (MEM_WE !== 1'b0) $display("FAIL rmid_we: got %b want 0", MEM_WE); else n_pass++;
    n_checks++; if (MEM_ADDR !== 23'h0) $display("FAIL rmid_addr: got %h want 0", MEM_ADDR); else n_pass++;
    n_checks++; if (MEM_WDATA !== 16'h0) $display("FAIL rmid_wdata: got %h want 0", MEM_WDATA); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL rmid_busy: got %b want 0", BUSY); else n_pass++;
    n_checks++; if (nBR !== 1'b1) $display("FAIL rmid_nbr: got %b want 1", nBR); else n_pass++;
    tick(); tick();
    nRESET = 1'b1; nBG = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (irq_cnt - i0 !== 0) $display("FAIL rmid_nirq: got %0d want 0", irq_cnt - i0); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL rmid_idle: got %b want 0", BUSY); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_copy();
    test_zero_count();
    test_stop_in_read();
    test_stop_busreq();
    test_start_while_busy();
    test_fill();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cd_dma_ctrl.md
CD_DMA_CTRL -- requirements
Module: cd_dma_ctrl

Interface
REQ-001 SHALL have port CLK_68KCLK  input  1  system clock; all state updates on its falling edge.
REQ-002 SHALL have port nRESET  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port DMA_START  input  1  one-cycle start pulse from the CD register block.
REQ-004 SHALL have port DMA_STOP  input  1  abort request, level-sensitive.
REQ-005 SHALL have port DMA_FILL  input  1  mode: 1 = fill with DMA_VALUE, 0 = copy.
REQ-006 SHALL have ports DMA_SOURCE, DMA_DEST  input  23 each  word addresses [23:1].
REQ-007 SHALL have ports DMA_VALUE  input  16  fill word; DMA_COUNT  input  16  transfer length in words.
REQ-008 SHALL have ports nBR  output  1 (bus request); nBG  input  1 (bus grant); nBGACK  output  1 (grant acknowledge).
REQ-009 SHALL have ports MEM_REQ  output  1; MEM_WE  output  1; MEM_ADDR  output  23; MEM_WDATA  output  16; MEM_RDATA  input  16; MEM_ACK  input  1.
REQ-010 SHALL have ports BUSY  output  1 (engine active) and DONE_IRQ  output  1 (one-cycle completion pulse).

Function
REQ-011 SHALL implement states IDLE, BUSREQ, READ, WRITE, RELEASE.
REQ-012 SHALL, in IDLE on DMA_START with DMA_COUNT != 0, latch SOURCE/DEST/VALUE/COUNT/mode, assert nBR=0 and BUSY=1, and go to BUSREQ.
REQ-013 SHALL, on DMA_START with DMA_COUNT == 0, pulse DONE_IRQ the next cycle without asserting nBR.
REQ-014 SHALL ignore DMA_START while BUSY=1.
REQ-015 SHALL leave BUSREQ once nBG=0 is sampled: drive nBGACK=0, nBR=1, enter READ (copy) or WRITE (fill).
REQ-016 SHALL in READ hold MEM_REQ=1, MEM_WE=0, MEM_ADDR=source pointer until MEM_ACK=1, then capture MEM_RDATA and enter WRITE.
REQ-017 SHALL in WRITE hold MEM_REQ=1, MEM_WE=1, MEM_ADDR=dest pointer, MEM_WDATA=captured word (copy) or latched VALUE (fill) until MEM_ACK=1.
REQ-018 SHALL on each WRITE acknowledge increment dest (and source in copy) by 1 word and decrement remaining count by 1.
REQ-019 SHALL wrap pointers modulo 2^23 words without error.
REQ-020 SHALL deassert MEM_REQ for at least one cycle between consecutive accesses.
REQ-021 SHALL enter RELEASE when remaining count reaches 0 or DMA_STOP=1 after a WRITE acknowledge.
REQ-022 SHALL never abort an access mid-handshake: DMA_STOP is honoured only at WRITE completion, or in BUSREQ (drop nBR, go IDLE, no IRQ).
REQ-023 SHALL in RELEASE drive nBGACK=1, BUSY=0, pulse DONE_IRQ for one cycle, return to IDLE.
REQ-024 SHALL pulse DONE_IRQ on abort-after-grant as well as normal completion.
REQ-025 SHALL give DMA_STOP priority over DMA_START when both asserted in IDLE (start ignored).

Reset
REQ-026 SHALL on nRESET=0 force IDLE, nBR=1, nBGACK=1, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, BUSY=0, DONE_IRQ=0, count and pointers 0.
REQ-027 SHALL, on reset mid-transfer, release the bus immediately with no DONE_IRQ.

Configuration
REQ-028 SHALL compile fill mode only when CD_DMA_FILL_EN is defined.
REQ-029 SHALL, without CD_DMA_FILL_EN, ignore DMA_FILL and perform copy for every transfer.

Structure
REQ-030 SHALL place the state enum and word-address width constant in shared package cd_dma_pkg.
REQ-031 SHALL isolate the MEM_REQ/MEM_ACK single-access handshake in sub-module cd_dma_access.

Verification
REQ-032 Copy: SOURCE=0x100000, DEST=0x200000, COUNT=3, nBG=0 after 2 cycles -> reads 0x100000..0x100002, writes same data to 0x200000..0x200002, one DONE_IRQ, nBGACK high after.
REQ-033 Fill (CD_DMA_FILL_EN): DEST=0x7FFFFE, COUNT=4, VALUE=0xA5A5 -> writes at 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001, no reads.
REQ-034 COUNT=0 start -> DONE_IRQ next cycle, nBR never low.
REQ-035 DMA_STOP raised during 2nd READ of COUNT=5 copy -> 2nd write completes, exactly 2 writes total, DONE_IRQ, bus released.
REQ-036 nRESET low during WRITE of COUNT=8 -> all outputs at reset values asynchronously, no DONE_IRQ; DMA_START while BUSY -> no relatch of parameters.
